// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI master
package spi_pkg;

  // Controller states
  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    GAP
  } spi_state_e;

  // SPI modes encoded as {CPOL, CPHA}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  // Width of the chip-select index; a single slave still needs one bit
  function automatic int cs_width(input int num_cs);
    return (num_cs > 1) ? $clog2(num_cs) : 1;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// rtl/spi_clk_div.sv - SCK half-period divider with synchronous clear
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic tick_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == DIV_W'(CLK_DIV - 1));

  // Wrap at terminal count; clear restarts the half-period on state entry
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear_i || tick_o) begin
      cnt_d = '0;
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - full-duplex SPI master with one-hot chip selects
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int CLK_DIV    = 4,
  parameter bit CPOL       = 1'b0,
  parameter bit CPHA       = 1'b0,
  parameter int NUM_CS     = 1,
  parameter int CS_GAP     = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [DATA_WIDTH-1:0]       tx_data,
  input  logic [cs_width(NUM_CS)-1:0] cs_sel,
  output logic                        busy,
  output logic [DATA_WIDTH-1:0]       rx_data,
  output logic                        rx_valid,
  output logic                        sck,
  output logic                        mosi,
  input  logic                        miso,
  output logic [NUM_CS-1:0]           ssel_n
);

  localparam logic [1:0] MODE           = {CPOL, CPHA};
  localparam bit         SAMPLE_ON_LEAD = (MODE == SPI_MODE0) || (MODE == SPI_MODE2);
  localparam bit         DRIVE_ON_LEAD  = (MODE == SPI_MODE1) || (MODE == SPI_MODE3);
  localparam int         CNT_MAX        = (2 * DATA_WIDTH > CS_GAP) ? 2 * DATA_WIDTH : CS_GAP;
  localparam int         CNT_W          = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(2 * DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(CS_GAP - 1);

  spi_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_CS-1:0]     ssel_n_q, ssel_n_d;
  logic                  sck_q, sck_d;
  logic                  mosi_q, mosi_d;
  logic                  busy_q, busy_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  tick;
  logic                  div_clear;

  // Divider idles at zero and restarts whenever a new state is entered
  assign div_clear = (state_q == IDLE) || (state_d != state_q);

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk    (clk),
    .rst    (rst),
    .clear_i(div_clear),
    .tick_o (tick)
  );

  // Next-state and datapath: edge counter doubles as the GAP cycle counter
  always_comb begin
    state_d    = state_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    cnt_d      = cnt_q;
    ssel_n_d   = ssel_n_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    rx_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && (int'(cs_sel) < NUM_CS)) begin
          state_d  = SETUP;
          tx_sr_d  = tx_data;
          cnt_d    = '0;
          ssel_n_d = ~(NUM_CS'(1) << cs_sel);
          if (!DRIVE_ON_LEAD) begin
            mosi_d = tx_data[DATA_WIDTH-1];
          end
        end
      end
      SETUP: begin
        if (tick) begin
          state_d = XFER;
          cnt_d   = '0;
        end
      end
      XFER: begin
        if (tick) begin
          sck_d = ~sck_q;
          cnt_d = cnt_q + 1'b1;
          if (!cnt_q[0]) begin
            // Leading edge: even edge index
            if (SAMPLE_ON_LEAD) begin
              rx_sr_d = {rx_sr_q[DATA_WIDTH-2:0], miso};
            end else begin
              mosi_d  = tx_sr_q[DATA_WIDTH-1];
              tx_sr_d = tx_sr_q << 1;
            end
          end else begin
            // Trailing edge: odd edge index
            if (SAMPLE_ON_LEAD) begin
              if (cnt_q != LAST_EDGE) begin
                mosi_d  = tx_sr_q[DATA_WIDTH-2];
                tx_sr_d = tx_sr_q << 1;
              end
            end else begin
              rx_sr_d = {rx_sr_q[DATA_WIDTH-2:0], miso};
            end
          end
          if (cnt_q == LAST_EDGE) begin
            state_d = HOLD;
            cnt_d   = '0;
            sck_d   = CPOL;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          state_d    = GAP;
          cnt_d      = '0;
          ssel_n_d   = '1;
          rx_data_d  = rx_sr_q;
          rx_valid_d = 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          mosi_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers; reset returns all outputs to idle levels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      cnt_q      <= '0;
      ssel_n_q   <= '1;
      sck_q      <= CPOL;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      cnt_q      <= cnt_d;
      ssel_n_q   <= ssel_n_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign busy     = busy_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign sck      = sck_q;
  assign mosi     = mosi_q;
  assign ssel_n   = ssel_n_q;

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
Parametrised full-duplex SPI master for ADC/DAC front ends.
- Generates its own SCK from clk through a programmable divider.
- Drives MOSI; supports all four CPOL/CPHA modes.
- Provides NUM_CS one-hot chip selects (active low).
- Uses a start/busy/rx_valid handshake toward the sample-processing logic.

Parameters:
DATA_WIDTH, 12, bits per transfer; MSB first.
CLK_DIV, 4, clk cycles per SCK half-period; legal range >= 1.
CPOL, 0, SCK idle level.
CPHA, 0, 0 = sample on leading edge; 1 = sample on trailing edge.
NUM_CS, 1, number of chip-select outputs; legal range >= 1.
CS_GAP, 2, minimum clk cycles ssel_n stays high between transfers; legal range >= 1.

Ports:
clk  input  1  system clock; one clock domain.
rst  input  1  reset; asynchronous, active-high.
start  input  1  request a transfer; sampled only in IDLE.
tx_data  input  DATA_WIDTH  word to send; latched on accepted start.
cs_sel  input  $clog2(NUM_CS) (min 1)  target slave index; latched on accepted start.
busy  output  1  high from the cycle after an accepted start until the return to IDLE.
rx_data  output  DATA_WIDTH  last received word; held until the next rx_valid.
rx_valid  output  1  one-cycle pulse when rx_data updates.
sck  output  1  SPI clock, registered.
mosi  output  1  master out, registered.
miso  input  1  master in; synchronised by the board, sampled directly.
ssel_n  output  NUM_CS  active-low chip selects; at most one is low at a time.

Behaviour:
- Reset values (applied immediately on rst, including mid-transfer): sck=CPOL, mosi=0, ssel_n=all ones, busy=0, rx_valid=0, rx_data=0, state=IDLE, divider=0.
- Divider: counts 0..CLK_DIV-1 while not in IDLE; tick = terminal count. The divider restarts at 0 on every state entry.
- IDLE:
  - start=1 and cs_sel<NUM_CS: latch tx_data into the shift register, latch cs_sel, go to SETUP.
  - start=1 and cs_sel>=NUM_CS: ignore start; stay IDLE.
- SETUP (CLK_DIV cycles): ssel_n[cs] goes low on entry. If CPHA=0, mosi = shift-register MSB on entry. On tick, go to XFER.
- XFER (2*DATA_WIDTH ticks): sck toggles on every tick; an edge counter counts 0..2*DATA_WIDTH-1.
  - Leading edge (sck leaves CPOL): if CPHA=0, sample miso into the rx shift register; if CPHA=1, drive mosi with the next bit.
  - Trailing edge: if CPHA=0, drive mosi with the next bit (none after the final edge); if CPHA=1, sample miso.
  - After the last edge, sck = CPOL; go to HOLD.
- HOLD (CLK_DIV cycles): ssel_n stays low. On tick:
  - ssel_n goes all high;
  - rx_data takes the receive register;
  - rx_valid=1 for exactly that cycle;
  - go to GAP.
- GAP (CS_GAP cycles): busy stays high; start is ignored. At the end, go to IDLE; busy=0 in that same cycle.
- Total busy time per transfer: CLK_DIV + 2*DATA_WIDTH*CLK_DIV + CLK_DIV + CS_GAP cycles.
- start is not queued: start while busy is lost. Upstream holds start until it sees busy rise.
- tx_data and cs_sel changes after acceptance do not affect the running transfer.
- Back-to-back transfers: start asserted in the first IDLE cycle is accepted; minimum inter-transfer ssel_n-high time is CS_GAP+1 cycles.
- CLK_DIV=1: sck toggles every clk cycle in XFER; all timing rules above still hold.
- mosi holds its last value outside XFER/SETUP. After GAP it returns to 0.

Decomposition:
- Package spi_pkg:
  - state enum IDLE/SETUP/XFER/HOLD/GAP;
  - mode constants SPI_MODE0..3 as {CPOL,CPHA} pairs;
  - helper function for cs_sel width (max(1,$clog2(NUM_CS))).
- Sub-module spi_clk_div: divider counter with a clear input, parameter CLK_DIV, output tick.
- FSM, shift registers and edge counter stay in spi_master_ctrl.

Test Plan:
- Mode 0, DATA_WIDTH=12, CLK_DIV=2, CS_GAP=2; slave model returns 0xA5C; tx_data=0x3C1 -> slave captures 0x3C1, rx_data=0xA5C with a one-cycle rx_valid, busy high exactly 54 cycles, 24 sck edges.
- Mode 3 (CPOL=1, CPHA=1), same words -> sck idles high, same rx/tx values, mosi changes only on falling sck edges.
- NUM_CS=4, cs_sel=2 then cs_sel=5 -> first transfer lowers only ssel_n[2]; second start is ignored and busy stays 0.
- Start pulsed during XFER and during GAP -> ignored; rx_valid pulses once; next start in the first IDLE cycle is accepted with ssel_n high for CS_GAP+1 cycles.
- rst asserted mid-XFER -> same cycle: ssel_n=all ones, sck=CPOL, busy=0, rx_valid=0. After release, a new transfer of 0xFFF/0x000 completes correctly.
- CLK_DIV=1, mode 1 -> sck period is 2 clk cycles; tx/rx words of 0x800 and 0x001 are correct, checking MSB-first ordering.
